// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between I-fetch and data requesters; LATENCY access cycles + 1 RESP cycle per grant.
// Requesters hold req until their one-cycle ready pulse; ARB_ROUND_ROBIN_EN swaps fixed D priority for alternation.
module mem_port_arbiter #(
   parameter int LATENCY = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ready,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ready,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   output logic              m_read,
   output logic              m_write,
   input  logic [DATA_W-1:0] m_rdata,
   output logic              busy
);

   localparam int               CNT_W    = $clog2(LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
   localparam logic             OWN_I    = 1'b0;
   localparam logic             OWN_D    = 1'b1;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             owner;
   logic             lat_we;
   logic             grant_d;
   logic             start;
   logic             last_cnt;

   assign start    = (state == IDLE) && (i_req || d_req);
   assign last_cnt = (cnt == '0);

`ifdef ARB_ROUND_ROBIN_EN
   logic last_owner;

   // On contention the side that lost the previous grant goes first.
   always_comb begin
      grant_d = d_req;
      if (i_req && d_req)
         grant_d = (last_owner == OWN_I);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         last_owner <= OWN_I;
      else if (start)
         last_owner <= grant_d;
   end
`else
   // MEM stage holds the older instruction, so data always wins.
   assign grant_d = d_req;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_req || d_req) state_nxt = ACCESS;
         ACCESS:  if (last_cnt)       state_nxt = RESP;
         RESP:                        state_nxt = IDLE;
         default:                     state_nxt = IDLE;
      endcase
   end

   // Strobes are decoded from registered state only, so they drop the instant reset asserts.
   always_comb begin
      i_ready = (state == RESP) && (owner == OWN_I);
      d_ready = (state == RESP) && (owner == OWN_D);
      m_read  = (state == ACCESS) && !lat_we;
      m_write = (state == ACCESS) && lat_we && last_cnt;
      busy    = (state != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt     <= '0;
         owner   <= OWN_I;
         lat_we  <= 1'b0;
         m_addr  <= '0;
         m_wdata <= '0;
         i_rdata <= '0;
         d_rdata <= '0;
      end else begin
         if (start) begin
            cnt    <= CNT_LOAD;
            owner  <= grant_d;
            lat_we <= grant_d && d_we;
            m_addr <= grant_d ? d_addr : i_addr;
            if (grant_d)
               m_wdata <= d_wdata;
         end else if (state == ACCESS && !last_cnt) begin
            cnt <= cnt - 1'b1;
         end

         if (state == ACCESS && last_cnt && !lat_we) begin
            if (owner == OWN_D)
               d_rdata <= m_rdata;
            else
               i_rdata <= m_rdata;
         end
      end
   end

endmodule
